serial_bit_feeder: RTL and testbench

Upstream stage for the single-shot 1001 sequence detector. It buffers parallel words from the producer in a small FIFO and serialises them into a continuous one-bit-per-clock stream on `x`. It watches the detector's match output and freezes the stream permanently once a match is reported. It drives the detector's `x` input directly and takes the detector's `y` output back as `match`.

---
 rtl/serial_feeder_pkg.sv | 5 +
 rtl/word_fifo.sv | 37 +++
 rtl/serial_bit_feeder.sv | 66 ++++++
 tb/tb_serial_bit_feeder.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/serial_feeder_pkg.sv
// serial_feeder_pkg: shared state type and counter width for the serial bit feeder
package serial_feeder_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, HALT} feeder_state_t;
  localparam int WORDS_SENT_W = 8;
endpackage

// File: rtl/word_fifo.sv
// word_fifo: circular word FIFO; push/pop strobes, din/dout data, full/empty flags, async reset
module word_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign full = r_cnt == (AW+1)'(DEPTH);
  assign empty = r_cnt == '0;
  assign w_push = push && !full;
  assign w_pop = pop && !empty;
  assign dout = r_mem[r_rp];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= din;
endmodule

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: FIFO-buffered word serialiser feeding a 1001 detector, frozen on match
// ports: in_valid/in_data/in_ready word input, match detector feedback, x/x_valid serial out,
// busy/halted state flags, words_sent saturating count of fully shifted words
module serial_bit_feeder
  import serial_feeder_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter int   DEPTH     = 4,
  parameter int   MSB_FIRST = 1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        in_data,
  output logic                    in_ready,
  input  logic                    match,
  output logic                    x,
  output logic                    x_valid,
  output logic                    busy,
  output logic                    halted,
  output logic [WORDS_SENT_W-1:0] words_sent
);
  localparam int CW = $clog2(WIDTH+1);
  feeder_state_t r_state, w_state_nx;
  logic [WIDTH-1:0] r_sr, w_sr_nx, w_dout;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [WORDS_SENT_W-1:0] r_ws;
  logic r_x, r_xv, w_x_nx, w_full, w_empty, w_last, w_load, w_done;
  word_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(in_valid && in_ready), .pop(w_load),
    .din(in_data), .dout(w_dout), .full(w_full), .empty(w_empty)
  );
  assign halted = r_state == HALT;
  assign busy = r_state == SHIFT;
  assign in_ready = !w_full && !halted;
  assign w_last = busy && r_cnt == CW'(1);
  // match wins over load, shift and the word count on the same edge
  assign w_load = !match && !w_empty && (r_state == IDLE || w_last);
  assign w_done = !match && w_last;
  always_comb begin
    w_state_nx = (match || halted) ? HALT : w_load ? SHIFT : w_last ? IDLE : r_state;
    w_sr_nx = w_load ? w_dout : busy ? ((MSB_FIRST != 0) ? r_sr << 1 : r_sr >> 1) : r_sr;
    w_cnt_nx = w_load ? CW'(WIDTH) : busy ? r_cnt - CW'(1) : r_cnt;
    w_x_nx = (w_state_nx == SHIFT) ? ((MSB_FIRST != 0) ? w_sr_nx[WIDTH-1] : w_sr_nx[0]) : IDLE_BIT;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_sr <= '0;
      r_cnt <= '0;
      r_ws <= '0;
      r_x <= IDLE_BIT;
      r_xv <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_sr <= w_sr_nx;
      r_cnt <= w_cnt_nx;
      if (w_done && r_ws != '1) r_ws <= r_ws + WORDS_SENT_W'(1);
      r_x <= w_x_nx;
      r_xv <= w_state_nx == SHIFT;
    end
  assign x = r_x;
  assign x_valid = r_xv;
  assign words_sent = r_ws;
endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb_serial_bit_feeder: directed self-checking bench for serial_bit_feeder
module tb_serial_bit_feeder;
  logic clk = 0, reset = 1, in_valid = 0, match = 0, in_valid2 = 0;
  logic [7:0] in_data = 0, in_data2 = 0;
  logic in_ready, x, x_valid, busy, halted, in_ready2, x2, x_valid2, busy2, halted2;
  logic [7:0] words_sent, words_sent2;
  logic [63:0] bits, bits2;
  int nb, nb2, runs, n_cmp = 0, n_err = 0;
  logic pv = 0;
  serial_bit_feeder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .match(match), .x(x), .x_valid(x_valid), .busy(busy), .halted(halted), .words_sent(words_sent)
  );
  serial_bit_feeder #(.MSB_FIRST(0)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
    .match(match), .x(x2), .x_valid(x_valid2), .busy(busy2), .halted(halted2), .words_sent(words_sent2)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (x_valid) begin
      bits = {bits[62:0], x};
      nb++;
      if (!pv) runs++;
    end
    pv = x_valid;
    if (x_valid2) begin
      bits2 = {bits2[62:0], x2};
      nb2++;
    end
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clr;
    bits = 0; bits2 = 0; nb = 0; nb2 = 0; runs = 0;
  endtask
  task automatic do_reset;
    reset = 1; in_valid = 0; in_valid2 = 0; match = 0;
    tick;
    reset = 0;
    clr;
  endtask
  initial begin
    logic [7:0] w [6];
    int stall, stall_pre, bad;
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44; w[4] = 8'h55; w[5] = 8'h66;
    #2;
    check("rst_x", x, 0);
    check("rst_xv", x_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_ws", words_sent, 0);
    check("rst_ready", in_ready, 1);
    do_reset;
    in_valid = 1; in_data = 8'hA5;
    tick;
    in_valid = 0;
    check("a5_lat0_xv", x_valid, 0);
    tick;
    check("a5_first_xv", x_valid, 1);
    check("a5_first_x", x, 1);
    repeat (7) tick;
    check("a5_last_xv", x_valid, 1);
    check("a5_last_ws", words_sent, 0);
    tick;
    check("a5_idle_xv", x_valid, 0);
    check("a5_idle_x", x, 0);
    check("a5_ws", words_sent, 1);
    check("a5_busy", busy, 0);
    check("a5_nb", nb, 8);
    check("a5_bits", bits[7:0], 8'hA5);
    check("a5_runs", runs, 1);
    do_reset;
    in_valid = 1; in_data = 8'h3C;
    tick;
    in_data = 8'hF0;
    tick;
    in_valid = 0;
    repeat (25) tick;
    check("b2b_bits", bits[15:0], 16'h3CF0);
    check("b2b_nb", nb, 16);
    check("b2b_runs", runs, 1);
    check("b2b_ws", words_sent, 2);
    do_reset;
    stall_pre = 0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1; in_data = w[k]; stall = 0;
      while (!in_ready && stall < 50) begin
        tick;
        stall++;
      end
      if (k == 5) check("full_stall", stall, 5);
      else stall_pre += stall;
      tick;
    end
    in_valid = 0;
    check("full_prestall", stall_pre, 0);
    repeat (60) tick;
    check("six_bits", bits[47:0], 48'h112233445566);
    check("six_nb", nb, 48);
    check("six_runs", runs, 1);
    check("six_ws", words_sent, 6);
    do_reset;
    in_valid = 1; in_data = 8'hFF;
    tick;
    in_valid = 0;
    repeat (3) tick;
    match = 1;
    tick;
    match = 0;
    check("halt_halted", halted, 1);
    check("halt_xv", x_valid, 0);
    check("halt_x", x, 0);
    check("halt_ready", in_ready, 0);
    check("halt_ws", words_sent, 0);
    check("halt_nb", nb, 3);
    in_valid = 1; in_data = 8'h55; bad = 0;
    repeat (100) begin
      tick;
      if (!halted || x_valid || in_ready || busy || words_sent != 0) bad++;
    end
    check("halt_persist", bad, 0);
    do_reset;
    check("halt_rst_halted", halted, 0);
    check("halt_rst_ready", in_ready, 1);
    do_reset;
    in_valid = 1; in_data = 8'hAA;
    tick;
    in_data = 8'hBB;
    tick;
    in_data = 8'hCC;
    tick;
    in_valid = 0;
    tick;
    check("mid_busy", busy, 1);
    #2 reset = 1;
    #1;
    check("mid_rst_xv", x_valid, 0);
    check("mid_rst_x", x, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", in_ready, 1);
    tick;
    reset = 0;
    clr;
    in_valid = 1; in_data = 8'h5A;
    tick;
    in_valid = 0;
    repeat (30) tick;
    check("mid_new_bits", bits[7:0], 8'h5A);
    check("mid_new_nb", nb, 8);
    check("mid_new_ws", words_sent, 1);
    do_reset;
    in_valid2 = 1; in_data2 = 8'h01;
    tick;
    in_valid2 = 0;
    repeat (12) tick;
    check("lsb_bits", bits2[7:0], 8'h80);
    check("lsb_nb", nb2, 8);
    check("lsb_ws", words_sent2, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
